// File: rtl/countdown_fsm_if.sv
// countdown_fsm_if: load request, start value and 7-segment display drive
// for the countdown timer. The master drives set/switch_number; the slave
// (the timer) drives cathode/anode.
interface countdown_fsm_if;
    logic       set;
    logic [7:0] switch_number;
    logic [6:0] cathode;
    logic [7:0] anode;

    modport master (
        output set,
        output switch_number,
        input  cathode,
        input  anode
    );

    modport slave (
        input  set,
        input  switch_number,
        output cathode,
        output anode
    );
endinterface

// File: rtl/countdown_fsm.sv
// countdown_fsm: loads an 8-bit start value, counts down by one per tick to
// zero, and shows the count in decimal on the three rightmost digits of a
// multiplexed common-anode 7-segment display.
// Optional feature macro: DONE_BLINK_EN (blink the "000" display while DONE).
module countdown_fsm #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic           clock,
    input  logic           reset,
    countdown_fsm_if.slave bus
);
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    count;
    logic [TW-1:0] tick_cnt;
    logic          tick_wrap;
    logic          tick_en;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit_idx;
    logic          blink;
    logic [19:0]   dd;
    logic [3:0]    digit;
    logic [2:0]    digit_sel;
    logic [7:0]    anode_next;
    logic [6:0]    anode_cathode_unused;
    logic [7:0]    anode_q;
    logic [6:0]    cathode_q;

    assign anode_cathode_unused = '0;
    assign bus.anode   = anode_q;
    assign bus.cathode = cathode_q;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign tick_wrap = (tick_cnt == TICK_LAST);

    // Tick counter runs only while counting (and, with blinking, in DONE)
    always_comb begin
`ifdef DONE_BLINK_EN
        tick_en = (state == RUN) || (state == DONE);
`else
        tick_en = (state == RUN);
`endif
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: set overrides everything below reset
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.set) state_next = LOAD;
            LOAD: begin
                if (!bus.set) state_next = (count != 8'd0) ? RUN : DONE;
            end
            RUN: begin
                if (bus.set)                          state_next = LOAD;
                else if (tick_wrap && count == 8'd1)  state_next = DONE;
            end
            DONE: if (bus.set) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Count: load on every set cycle so the last set value wins; decrement on tick wrap
    always_ff @(posedge clock) begin
        if (!reset)                                          count <= '0;
        else if (bus.set)                                    count <= bus.switch_number;
        else if (state == RUN && tick_wrap && count != 8'd0) count <= count - 8'd1;
    end

    // Tick counter: 0..TICK_DIV-1, cleared whenever not enabled
    always_ff @(posedge clock) begin
        if (!reset || bus.set || !tick_en) tick_cnt <= '0;
        else if (tick_wrap)                tick_cnt <= '0;
        else                               tick_cnt <= tick_cnt + 1'b1;
    end

`ifdef DONE_BLINK_EN
    // Blink flag: cleared outside DONE so every entry to DONE starts visible
    always_ff @(posedge clock) begin
        if (!reset || state != DONE || bus.set) blink <= 1'b0;
        else if (tick_wrap)                     blink <= ~blink;
    end
`else
    // Blinking disabled: display always visible
    always_comb blink = 1'b0;
`endif

    // Scan counter and digit index: advance 0->1->2->0 at each scan wrap
    always_ff @(posedge clock) begin
        if (!reset) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
        end
    end

    // Binary to BCD (shift-and-add-3); BCD ends up in dd[19:8]
    always_comb begin
        dd = {12'd0, count};
        for (int unsigned i = 0; i < 8; i++) begin
            if (dd[11:8]  >= 4'd5) dd[11:8]  = dd[11:8]  + 4'd3;
            if (dd[15:12] >= 4'd5) dd[15:12] = dd[15:12] + 4'd3;
            if (dd[19:16] >= 4'd5) dd[19:16] = dd[19:16] + 4'd3;
            dd = dd << 1;
        end
    end

    // Select the digit value and anode line for the current scan position
    always_comb begin
        digit     = dd[11:8];
        digit_sel = 3'b110;
        case (digit_idx)
            2'd1: begin
                digit     = dd[15:12];
                digit_sel = 3'b101;
            end
            2'd2: begin
                digit     = dd[19:16];
                digit_sel = 3'b011;
            end
            default: begin
                digit     = dd[11:8];
                digit_sel = 3'b110;
            end
        endcase
        anode_next = blink ? 8'hFF : {5'b11111, digit_sel};
    end

    // Registered display drive: anode and cathode update together
    always_ff @(posedge clock) begin
        if (!reset) begin
            anode_q   <= 8'b1111_1110;
            cathode_q <= 7'b1000000;
        end else begin
            anode_q   <= anode_next;
            cathode_q <= seg7(digit) | anode_cathode_unused;
        end
    end
endmodule

// File: tb/tb_countdown_fsm.sv
// tb_countdown_fsm: scoreboard bench for countdown_fsm with TICK_DIV=4,
// SCAN_DIV=2. A behavioural model predicts each registered display word
// before the clock edge; the prediction is queued and compared afterwards.
module tb_countdown_fsm;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned SCAN_DIV = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    countdown_fsm_if bus();

    countdown_fsm #(
        .TICK_DIV(TICK_DIV),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [14:0] exp_q[$];

    typedef enum {M_IDLE, M_LOAD, M_RUN, M_DONE} mstate_t;
    mstate_t m_st    = M_IDLE;
    int      m_cnt   = 0;
    int      m_tick  = 0;
    int      m_scan  = 0;
    int      m_idx   = 0;
    bit      m_blink = 1'b0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    task automatic check_val(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: anode/cathode got %h_%b, expected %h_%b",
                     tag, obs[14:7], obs[6:0], exp[14:7], exp[6:0]);
        end
    endtask

    function automatic logic [14:0] model_out();
        int d;
        logic [7:0] an;
        case (m_idx)
            0:       d = m_cnt % 10;
            1:       d = (m_cnt / 10) % 10;
            default: d = m_cnt / 100;
        endcase
        an = 8'hFF & ~(8'd1 << m_idx);
        if (m_blink) an = 8'hFF;
        return {an, seg_tab[d]};
    endfunction

    task automatic model_update();
        if (!reset) begin
            m_st = M_IDLE; m_cnt = 0; m_tick = 0; m_scan = 0; m_idx = 0; m_blink = 1'b0;
            return;
        end
        if (m_scan == SCAN_DIV - 1) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % 3;
        end else begin
            m_scan++;
        end
        if (bus.set) begin
            m_st = M_LOAD; m_cnt = int'(bus.switch_number); m_tick = 0; m_blink = 1'b0;
        end else begin
            case (m_st)
                M_IDLE: ;
                M_LOAD: begin
                    m_tick = 0;
                    m_st   = (m_cnt != 0) ? M_RUN : M_DONE;
                end
                M_RUN: begin
                    if (m_tick == TICK_DIV - 1) begin
                        m_tick = 0;
                        m_cnt--;
                        if (m_cnt == 0) m_st = M_DONE;
                    end else begin
                        m_tick++;
                    end
                end
                M_DONE: begin
`ifdef DONE_BLINK_EN
                    if (m_tick == TICK_DIV - 1) begin
                        m_tick  = 0;
                        m_blink = ~m_blink;
                    end else begin
                        m_tick++;
                    end
`else
                    m_tick = 0;
`endif
                end
                default: m_st = M_IDLE;
            endcase
        end
    endtask

    task automatic step(input string tag);
        logic [14:0] obs;
        exp_q.push_back(reset ? model_out() : {8'hFE, 7'b1000000});
        @(posedge clock);
        model_update();
        @(negedge clock);
        obs = {bus.anode, bus.cathode};
        check_val(tag, obs, exp_q.pop_front());
    endtask

    task automatic run(input string tag, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(tag);
    endtask

    task automatic load(input logic [7:0] v, input int unsigned n);
        bus.switch_number = v;
        bus.set = 1'b1;
        run("load", n);
        bus.set = 1'b0;
    endtask

    initial begin
        bus.set = 1'b0;
        bus.switch_number = 8'h00;

        // Reset held for two cycles, then idle with no counting
        reset = 1'b0;
        run("reset", 2);
        check_val("reset_disp", {bus.anode, bus.cathode}, {8'hFE, 7'b1000000});
        reset = 1'b1;
        run("idle", 8);

        // Load 0x55 (85): digits 0,8,5 scanned FE/FD/FB
        load(8'h55, 5);
        run("run85", 10);

        // Reset mid-countdown returns to "000" and stays there
        reset = 1'b0;
        run("mid_reset", 5);
        reset = 1'b1;
        run("post_reset", 12);
        check_val("post_reset_zero", {1'b0, 7'h00, bus.cathode}, {8'h00, 7'b1000000});

        // Countdown 3 -> 0, then 20 more cycles holding 0
        load(8'h03, 2);
        run("count3", 12 + 20 + 2);
        check_val("done_zero", {1'b0, 7'h00, bus.cathode}, {8'h00, 7'b1000000});

        // Reload during RUN, tracking switch changes while set is held
        load(8'd200, 1);
        run("run200", 10);
        bus.switch_number = 8'd9;
        bus.set = 1'b1;
        step("reload_a");
        load(8'd7, 1);
        run("count7", 7 * 4 + 8);

        // Zero load goes straight to DONE without decrementing
        load(8'd0, 2);
        run("zero_load", 12);
        check_val("zero_done", {1'b0, 7'h00, bus.cathode}, {8'h00, 7'b1000000});

        // Every decimal digit value, held long enough for a full scan
        for (int i = 0; i < 10; i++) load(8'(i * 11), 6);
        load(8'd100, 6);
        load(8'd255, 6);
        run("run255", 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/countdown_fsm.md
Name: countdown_fsm

Overview:
Countdown timer controller with a multiplexed 8-digit, common-anode 7-segment display driver. An 8-bit value from the switches is loaded with `set`. It then counts down by one per tick until it reaches zero. The current count is shown in decimal on the three rightmost digits. The block is the top-level control of the board-level countdown timer.

Parameters:
TICK_DIV, 100000000, clock cycles per countdown tick (1 s at 100 MHz); minimum 2
SCAN_DIV, 100000, clock cycles per display digit advance; minimum 2

Ports:
clock  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
set  input  1  active-high level load request, synchronous
switch_number  input  8  countdown start value, unsigned binary 0..255
cathode  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
anode  output  8  digit enables, active-low; bit 0 is the rightmost digit

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Priority: reset > set > counting.
- Reset values:
  - state=IDLE, count=0, tick counter=0, scan counter=0, digit index=0.
  - anode=8'b1111_1110, cathode=7'b1000000 (digit '0').
- States:
  - IDLE: count holds. set=1 -> LOAD.
  - LOAD: each cycle, count<=switch_number and tick counter<=0. set=0 -> RUN if count!=0, else DONE.
  - RUN: tick counter counts 0..TICK_DIV-1 and wraps. At the wrap cycle, count<=count-1. If count==1 at a wrap, count becomes 0 and state -> DONE that same edge. set=1 -> LOAD (abandons countdown).
  - DONE: count=0 and holds. set=1 -> LOAD.
- First decrement occurs TICK_DIV cycles after the first cycle in RUN.
- Count never wraps below 0.
- switch_number changes while set=1 are tracked; the value present on the last set=1 cycle wins.
- Reset mid-countdown returns to IDLE with count=0 on that edge.
- Display decoding:
  - Count is converted combinationally to BCD: hundreds (0..2), tens, ones.
  - Leading zeros are displayed.
- Display scanning:
  - Scan counter counts 0..SCAN_DIV-1. At wrap, digit index advances 0->1->2->0.
  - Digit index 0 = ones (anode[0] low), 1 = tens (anode[1] low), 2 = hundreds (anode[2] low).
  - anode[7:3] are always 1. Exactly one of anode[2:0] is low at any time.
- anode and cathode are registered and update together. Latency is one cycle from a count or digit-index change.
- Segment codes {g..a}, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Scanning runs in all states, including IDLE and LOAD.

Optional Feature:
Macro DONE_BLINK_EN.
- Defined: in DONE, the tick counter keeps running and a blink flag toggles at each tick wrap.
  - Blink flag is cleared on entry to DONE.
  - While the flag is 1, anode is forced to 8'hFF (all digits off).
  - While the flag is 0, scanning shows "000" normally.
- Not defined: DONE shows a steady "000"; the tick counter is idle in DONE.
- All other behaviour is identical with or without the macro.

Test Plan:
- Parameters TICK_DIV=4, SCAN_DIV=2 for all tests.
- Reset: hold reset=0 for 2 cycles -> anode=8'hFE, cathode=7'b1000000, count=0. Release; no counting occurs in IDLE.
- Load and display:
  - Apply switch_number=8'h55, then set=1 for 5 cycles.
  - Expect tens digit cathode=0000000 ('8'), ones=0010010 ('5'), hundreds=1000000 ('0').
  - anode cycles FE, FD, FB every 2 cycles.
- Countdown:
  - Release set after loading 8'h03.
  - Count goes 3->2->1->0 at 4, 8 and 12 cycles after entering RUN.
  - DONE is entered at the 12-cycle wrap. Count stays 0 for a further 20 cycles.
- Reset mid-count:
  - Load 85, run 10 cycles, assert reset=0 for 5 cycles.
  - Expect state=IDLE, count=0, display "000". No decrement after release.
- Reload and zero load:
  - set=1 during RUN restarts from the new switch_number.
  - Loading 0 and releasing set enters DONE directly with no decrement.
- DONE_BLINK_EN defined: in DONE, anode alternates between 8'hFF and scanning every 4 cycles.
